// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_ctrl_pkg
//  Description : Shared encodings for the multicycle MIPS control path.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADDR  = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECUTE  = 4'd6,
    ST_RCOMP    = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
    ST_ADDIEX   = 4'd10,
    ST_ORIEX    = 4'd11,
    ST_IMMCOMP  = 4'd12,
    ST_RSVD     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] ALUSRCB_REGB   = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic [1:0] aluOp;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       zeroExt;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       branchNe;
    logic [1:0] pcSource;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       instrDone;
    logic       illegalOp;
  } ctrl_out_t;

  localparam int CTRL_W = $bits(ctrl_out_t);

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J: is_legal_op = 1'b1;
      default: is_legal_op = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_output_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_output_decode
//  Description : Combinational map from control state (and opcode) to controls.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0]        state,
  input  logic [5:0]        op,
  output logic [CTRL_W-1:0] ctrl
);

  state_t    w_state;
  ctrl_out_t w_out;

  assign w_state = state_t'(state);
  assign ctrl    = w_out;

  always_comb begin
    w_out = '0;
    case (w_state)
      ST_FETCH: begin
        w_out.memRead  = 1'b1;
        w_out.irWrite  = 1'b1;
        w_out.pcWrite  = 1'b1;
        w_out.aluSrcB  = ALUSRCB_FOUR;
        w_out.aluOp    = ALUOP_ADD;
        w_out.pcSource = PCSRC_ALU;
      end
      ST_DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        w_out.aluSrcB   = ALUSRCB_BRANCH;
        w_out.aluOp     = ALUOP_ADD;
        w_out.illegalOp = ~is_legal_op(op);
      end
      ST_MEMADDR, ST_ADDIEX: begin
        w_out.aluSrcA = 1'b1;
        w_out.aluSrcB = ALUSRCB_IMM;
        w_out.aluOp   = ALUOP_ADD;
      end
      ST_MEMREAD: begin
        w_out.memRead = 1'b1;
        w_out.iorD    = 1'b1;
      end
      ST_MEMWB: begin
        w_out.regWrite  = 1'b1;
        w_out.memToReg  = 1'b1;
        w_out.instrDone = 1'b1;
      end
      ST_MEMWRITE: begin
        w_out.memWrite  = 1'b1;
        w_out.iorD      = 1'b1;
        w_out.instrDone = 1'b1;
      end
      ST_EXECUTE: begin
        w_out.aluSrcA = 1'b1;
        w_out.aluSrcB = ALUSRCB_REGB;
        w_out.aluOp   = ALUOP_RTYPE;
      end
      ST_RCOMP: begin
        w_out.regWrite  = 1'b1;
        w_out.regDst    = 1'b1;
        w_out.instrDone = 1'b1;
      end
      ST_BRANCH: begin
        w_out.aluSrcA     = 1'b1;
        w_out.aluSrcB     = ALUSRCB_REGB;
        w_out.aluOp       = ALUOP_SUB;
        w_out.pcWriteCond = 1'b1;
        w_out.pcSource    = PCSRC_ALUOUT;
        w_out.branchNe    = (op == OP_BNE);
        w_out.instrDone   = 1'b1;
      end
      ST_JUMP: begin
        w_out.pcWrite   = 1'b1;
        w_out.pcSource  = PCSRC_JUMP;
        w_out.instrDone = 1'b1;
      end
      ST_ORIEX: begin
        w_out.aluSrcA = 1'b1;
        w_out.aluSrcB = ALUSRCB_IMM;
        w_out.zeroExt = 1'b1;
        w_out.aluOp   = ALUOP_OR;
      end
      ST_IMMCOMP: begin
        w_out.regWrite  = 1'b1;
        w_out.instrDone = 1'b1;
      end
      default: w_out = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Main control FSM for the multicycle MIPS datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  output logic [1:0] aluOp,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic       zeroExt,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       branchNe,
  output logic [1:0] pcSource,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       regWrite,
  output logic       instrDone,
  output logic       illegalOp
);

  state_t            r_state;
  state_t            w_next;
  logic [CTRL_W-1:0] w_ctrl_bits;
  ctrl_out_t         w_ctrl;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = ST_FETCH;
    case (r_state)
      ST_FETCH: w_next = ST_DECODE;
      ST_DECODE: begin
        case (op)
          OP_LW, OP_SW:   w_next = ST_MEMADDR;
          OP_RTYPE:       w_next = ST_EXECUTE;
          OP_BEQ, OP_BNE: w_next = ST_BRANCH;
          OP_J:           w_next = ST_JUMP;
          OP_ADDI:        w_next = ST_ADDIEX;
          OP_ORI:         w_next = ST_ORIEX;
          default:        w_next = ST_FETCH;
        endcase
      end
      ST_MEMADDR: w_next = (op == OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
      ST_MEMREAD: w_next = ST_MEMWB;
      ST_EXECUTE: w_next = ST_RCOMP;
      ST_ADDIEX:  w_next = ST_IMMCOMP;
      ST_ORIEX:   w_next = ST_IMMCOMP;
      default:    w_next = ST_FETCH;
    endcase
  end

  ctrl_output_decode u_decode (
    .state (r_state),
    .op    (op),
    .ctrl  (w_ctrl_bits)
  );

  // Holding reset silences every strobe so no write escapes before FETCH.
  assign w_ctrl = reset ? '0 : ctrl_out_t'(w_ctrl_bits);

  assign aluOp       = w_ctrl.aluOp;
  assign aluSrcA     = w_ctrl.aluSrcA;
  assign aluSrcB     = w_ctrl.aluSrcB;
  assign zeroExt     = w_ctrl.zeroExt;
  assign pcWrite     = w_ctrl.pcWrite;
  assign pcWriteCond = w_ctrl.pcWriteCond;
  assign branchNe    = w_ctrl.branchNe;
  assign pcSource    = w_ctrl.pcSource;
  assign iorD        = w_ctrl.iorD;
  assign memRead     = w_ctrl.memRead;
  assign memWrite    = w_ctrl.memWrite;
  assign irWrite     = w_ctrl.irWrite;
  assign regDst      = w_ctrl.regDst;
  assign memToReg    = w_ctrl.memToReg;
  assign regWrite    = w_ctrl.regWrite;
  assign instrDone   = w_ctrl.instrDone;
  assign illegalOp   = w_ctrl.illegalOp;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Self-checking bench for the multicycle MIPS control FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  typedef struct packed {
    logic [1:0] aluOp;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       zeroExt;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       branchNe;
    logic [1:0] pcSource;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       instrDone;
    logic       illegalOp;
  } exp_t;

  localparam int P_FETCH = 0, P_DECODE = 1, P_DECODE_ILL = 2, P_MEMADDR = 3,
                 P_MEMREAD = 4, P_MEMWB = 5, P_MEMWRITE = 6, P_EXEC = 7,
                 P_RCOMP = 8, P_BRANCH = 9, P_JUMP = 10, P_ADDIEX = 11,
                 P_ORIEX = 12, P_IMM = 13;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000,
                         ORI = 6'b001101, JMP = 6'b000010, BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [1:0] aluOp, aluSrcB, pcSource;
  logic       aluSrcA, zeroExt, pcWrite, pcWriteCond, branchNe, iorD;
  logic       memRead, memWrite, irWrite, regDst, memToReg, regWrite;
  logic       instrDone, illegalOp;

  exp_t act;
  exp_t q[$];
  exp_t e;
  exp_t snap_first, snap_last;
  int   n_vec = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  bit   running = 1'b1;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op),
    .aluOp(aluOp), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .zeroExt(zeroExt),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .branchNe(branchNe),
    .pcSource(pcSource), .iorD(iorD), .memRead(memRead), .memWrite(memWrite),
    .irWrite(irWrite), .regDst(regDst), .memToReg(memToReg),
    .regWrite(regWrite), .instrDone(instrDone), .illegalOp(illegalOp)
  );

  always #5 clk = ~clk;

  assign act = {aluOp, aluSrcA, aluSrcB, zeroExt, pcWrite, pcWriteCond,
                branchNe, pcSource, iorD, memRead, memWrite, irWrite,
                regDst, memToReg, regWrite, instrDone, illegalOp};

  // Output word of each spec phase.
  function automatic exp_t ph(input int p, input bit bne);
    exp_t w = '0;
    case (p)
      P_FETCH:      begin w.memRead = 1; w.irWrite = 1; w.pcWrite = 1; w.aluSrcB = 2'b01; end
      P_DECODE:     w.aluSrcB = 2'b11;
      P_DECODE_ILL: begin w.aluSrcB = 2'b11; w.illegalOp = 1; end
      P_MEMADDR:    begin w.aluSrcA = 1; w.aluSrcB = 2'b10; end
      P_MEMREAD:    begin w.memRead = 1; w.iorD = 1; end
      P_MEMWB:      begin w.regWrite = 1; w.memToReg = 1; w.instrDone = 1; end
      P_MEMWRITE:   begin w.memWrite = 1; w.iorD = 1; w.instrDone = 1; end
      P_EXEC:       begin w.aluSrcA = 1; w.aluOp = 2'b10; end
      P_RCOMP:      begin w.regWrite = 1; w.regDst = 1; w.instrDone = 1; end
      P_BRANCH:     begin w.aluSrcA = 1; w.aluOp = 2'b01; w.pcWriteCond = 1;
                          w.pcSource = 2'b01; w.branchNe = bne; w.instrDone = 1; end
      P_JUMP:       begin w.pcWrite = 1; w.pcSource = 2'b10; w.instrDone = 1; end
      P_ADDIEX:     begin w.aluSrcA = 1; w.aluSrcB = 2'b10; end
      P_ORIEX:      begin w.aluSrcA = 1; w.aluSrcB = 2'b10; w.zeroExt = 1; w.aluOp = 2'b11; end
      P_IMM:        begin w.regWrite = 1; w.instrDone = 1; end
      default:      w = '0;
    endcase
    return w;
  endfunction

  function automatic int cpi_of(input logic [5:0] o);
    case (o)
      LW: return 5;
      SW, RT, ADDI, ORI: return 4;
      BEQ, BNE, JMP: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic push_instr(input logic [5:0] o);
    q.push_back(ph(P_FETCH, 0));
    case (o)
      LW:   begin q.push_back(ph(P_DECODE, 0)); q.push_back(ph(P_MEMADDR, 0));
                  q.push_back(ph(P_MEMREAD, 0)); q.push_back(ph(P_MEMWB, 0)); end
      SW:   begin q.push_back(ph(P_DECODE, 0)); q.push_back(ph(P_MEMADDR, 0));
                  q.push_back(ph(P_MEMWRITE, 0)); end
      RT:   begin q.push_back(ph(P_DECODE, 0)); q.push_back(ph(P_EXEC, 0));
                  q.push_back(ph(P_RCOMP, 0)); end
      ADDI: begin q.push_back(ph(P_DECODE, 0)); q.push_back(ph(P_ADDIEX, 0));
                  q.push_back(ph(P_IMM, 0)); end
      ORI:  begin q.push_back(ph(P_DECODE, 0)); q.push_back(ph(P_ORIEX, 0));
                  q.push_back(ph(P_IMM, 0)); end
      BEQ:  begin q.push_back(ph(P_DECODE, 0)); q.push_back(ph(P_BRANCH, 0)); end
      BNE:  begin q.push_back(ph(P_DECODE, 0)); q.push_back(ph(P_BRANCH, 1)); end
      JMP:  begin q.push_back(ph(P_DECODE, 0)); q.push_back(ph(P_JUMP, 0)); end
      default: q.push_back(ph(P_DECODE_ILL, 0));
    endcase
  endtask

  task automatic chk(input string name, input int a, input int b);
    n_vec++;
    if (a != b) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", name, a, b);
    end
  endtask

  // Per-cycle comparison against the model queue.
  always @(negedge clk) begin
    if (running) begin
      if (!reset && q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL model_underflow t=%0t actual=%h required=no active cycle", $time, act);
      end else begin
        e = reset ? exp_t'('0) : q.pop_front();
        n_vec++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL cycle t=%0t actual=%h required=%h", $time, act, e);
        end
      end
      if (!reset && instrDone) done_cnt++;
    end
  end

  task automatic run_instr(input logic [5:0] o, output int cyc);
    bit done;
    push_instr(o);
    op = o;
    cyc = 0;
    done = 0;
    while (!done && cyc < 8) begin
      @(negedge clk);
      if (cyc == 0) snap_first = act;
      snap_last = act;
      cyc++;
      done = instrDone;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL instr_timeout op=%b actual=no instrDone required=instrDone within 8 cycles", o);
    end
  endtask

  initial begin
    int c;
    int tot_cyc, exp_cyc, base;
    logic [5:0] legal [8];
    logic [5:0] o;
    exp_t s1, s2;
    legal = '{LW, SW, RT, BEQ, BNE, ADDI, ORI, JMP};
    reset = 1'b1;
    op = RT;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_instr(LW, c);
    chk("fetch_after_reset", {snap_first.memRead, snap_first.irWrite, snap_first.pcWrite}, 3'b111);
    chk("lw_cpi", c, 5);
    chk("memwb_fields", {snap_last.regWrite, snap_last.memToReg, snap_last.regDst, snap_last.instrDone}, 4'b1101);

    // Reset asserted in MEMREAD, held over two rising edges.
    push_instr(LW);
    op = LW;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    q.delete();
    @(negedge clk);
    chk("reset_all_zero", act, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    run_instr(RT, c);
    chk("fetch_after_midreset", {snap_first.memRead, snap_first.irWrite, snap_first.pcWrite}, 3'b111);
    chk("r_cpi", c, 4);
    chk("rcomp_fields", {snap_last.regDst, snap_last.regWrite}, 2'b11);

    run_instr(ORI, c);
    chk("ori_cpi", c, 4);
    chk("immcomp_regwrite", snap_last.regWrite, 1);

    run_instr(BNE, c);
    chk("bne_cpi", c, 3);
    chk("bne_fields", {snap_last.aluOp, snap_last.pcWriteCond, snap_last.pcSource, snap_last.branchNe}, 6'b01_1_01_1);

    run_instr(BEQ, c);
    chk("beq_cpi", c, 3);
    chk("beq_branchne", snap_last.branchNe, 0);

    run_instr(JMP, c);
    chk("j_cpi", c, 3);
    chk("jump_fields", {snap_last.pcWrite, snap_last.pcSource}, 3'b1_10);

    push_instr(BAD);
    op = BAD;
    @(negedge clk); s1 = act;
    @(posedge clk); #1;
    @(negedge clk); s2 = act;
    @(posedge clk); #1;
    chk("illegal_flag", s2.illegalOp, 1);
    chk("illegal_no_write", {s1.regWrite, s1.memWrite, s2.regWrite, s2.memWrite}, 0);

    run_instr(SW, c);
    chk("sw_cpi", c, 4);
    run_instr(ADDI, c);
    chk("addi_cpi", c, 4);

    tot_cyc = 0;
    exp_cyc = 0;
    base = done_cnt;
    for (int i = 0; i < 1000; i++) begin
      o = legal[$urandom_range(0, 7)];
      exp_cyc += cpi_of(o);
      run_instr(o, c);
      tot_cyc += c;
    end
    chk("stream_instrdone_count", done_cnt - base, 1000);
    chk("stream_cycle_total", tot_cyc, exp_cyc);
    chk("model_queue_drained", q.size(), 0);

    running = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
